// File: rtl/player_ctrl_if.sv
// rtl/player_ctrl_if.sv - signal bundle between the player control FSM and its environment
// slave  (player_ctrl): in  frame_tick, up_btn, down_btn, y_cur[7:0]
//                       out add_x, add_y[1:0], y_pos_mod, y_neg_mod, plot, colour[2:0], busy
// master (environment): the same signals with opposite directions
interface player_ctrl_if;
   logic       frame_tick;
   logic       up_btn;
   logic       down_btn;
   logic [7:0] y_cur;
   logic       add_x;
   logic [1:0] add_y;
   logic       y_pos_mod;
   logic       y_neg_mod;
   logic       plot;
   logic [2:0] colour;
   logic       busy;

   modport master (
      output frame_tick, up_btn, down_btn, y_cur,
      input  add_x, add_y, y_pos_mod, y_neg_mod, plot, colour, busy
   );

   modport slave (
      input  frame_tick, up_btn, down_btn, y_cur,
      output add_x, add_y, y_pos_mod, y_neg_mod, plot, colour, busy
   );
endinterface

// File: rtl/player_ctrl.sv
// rtl/player_ctrl.sv - ship erase/move/draw sequencer driving the player datapath and VGA strobes
// clk  : system clock
// rst  : asynchronous active-high reset
// bus  : player_ctrl_if.slave (frame_tick, buttons, y_cur in; sprite offsets, move pulses,
//        plot/colour strobes and busy out)
module player_ctrl #(
   parameter int         FRAME_DIV = 4,
   parameter int         Y_MIN     = 0,
   parameter int         Y_MAX     = 116,
   parameter logic [2:0] FG_COLOUR = 3'b111,
   parameter logic [2:0] BG_COLOUR = 3'b000
) (
   input logic          clk,
   input logic          rst,
   player_ctrl_if.slave bus
);
   localparam int               DIV_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);
   localparam logic [7:0]       Y_MIN_L  = 8'(Y_MIN);
   localparam logic [7:0]       Y_MAX_L  = 8'(Y_MAX);

   typedef enum logic [2:0] {
      S_INIT  = 3'd0,
      S_IDLE  = 3'd1,
      S_ERASE = 3'd2,
      S_MOVE  = 3'd3,
      S_DRAW  = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       cnt_q, cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             dir_up_q, dir_up_d;
   logic             opportunity;

   assign opportunity = bus.frame_tick && (div_q == DIV_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_INIT;
         cnt_q    <= '0;
         div_q    <= '0;
         dir_up_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         div_q    <= div_d;
         dir_up_q <= dir_up_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      div_d    = div_q;
      dir_up_d = dir_up_q;

      // The divider keeps running while busy so dropped opportunities do not shift the cadence.
      if ((state_q != S_INIT) && bus.frame_tick) begin
         div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
      end

      case (state_q)
         S_INIT: begin
            state_d = S_DRAW;
            cnt_d   = '0;
         end
         S_IDLE: begin
            // Buttons and y_cur matter only on the opportunity cycle; direction is latched here.
            if (opportunity) begin
               if (bus.up_btn && !bus.down_btn && (bus.y_cur > Y_MIN_L)) begin
                  dir_up_d = 1'b1;
                  state_d  = S_ERASE;
                  cnt_d    = '0;
               end else if (bus.down_btn && !bus.up_btn && (bus.y_cur < Y_MAX_L)) begin
                  dir_up_d = 1'b0;
                  state_d  = S_ERASE;
                  cnt_d    = '0;
               end
            end
         end
         S_ERASE: begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               state_d = S_MOVE;
            end
         end
         S_MOVE: begin
            state_d = S_DRAW;
            cnt_d   = '0;
         end
         S_DRAW: begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_INIT;
            cnt_d   = '0;
         end
      endcase
   end

   // cnt is zero outside ERASE/DRAW, so the sprite offsets are quiet in the other states.
   always_comb begin
      bus.add_x     = cnt_q[0];
      bus.add_y     = cnt_q[2:1];
      bus.plot      = 1'b0;
      bus.colour    = 3'b000;
      bus.y_pos_mod = 1'b0;
      bus.y_neg_mod = 1'b0;
      bus.busy      = 1'b1;
      case (state_q)
         S_IDLE: begin
            bus.busy = 1'b0;
         end
         S_ERASE: begin
            bus.plot   = 1'b1;
            bus.colour = BG_COLOUR;
         end
         S_MOVE: begin
            bus.y_neg_mod = dir_up_q;
            bus.y_pos_mod = !dir_up_q;
         end
         S_DRAW: begin
            bus.plot   = 1'b1;
            bus.colour = FG_COLOUR;
         end
         default: begin
            bus.busy = 1'b1;
         end
      endcase
   end
endmodule
